vga_crop_pack: RTL

Capture-side stage between the VGA decoder pins and the VGA-to-sequencer FIFO. It detects sync edges, counts pixels and lines, and crops the active window out of the incoming RGB888 stream. Each in-window pixel is packed to RGB565 and pushed as one 16-bit FIFO write. It also provides a frame-start pulse for the sequencer, a measured line length, and a sticky overflow flag.

---
 rtl/vga_crop_pack_if.sv | 21 ++
 rtl/vga_crop_pack.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_crop_pack_if.sv
// FIFO write-side bundle between the VGA capture stage and the
// VGA-to-sequencer FIFO.
interface vga_crop_pack_if;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;

  // Capture stage: issues writes, watches the full flag.
  modport master (
    input  fifo_full,
    output fifo_wr_en,
    output fifo_wr_data
  );

  // FIFO side: accepts writes, reports full.
  modport slave (
    output fifo_full,
    input  fifo_wr_en,
    input  fifo_wr_data
  );
endinterface

// File: rtl/vga_crop_pack.sv
// VGA capture stage: sync edge detection, pixel/line counting, active
// window crop, RGB888 -> RGB565 packing and FIFO write generation.
module vga_crop_pack #(
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vga_hsync,
  input  logic                   vga_vsync,
  input  logic [7:0]             vga_r,
  input  logic [7:0]             vga_g,
  input  logic [7:0]             vga_b,
  vga_crop_pack_if.master        fifo,
  output logic                   frame_start,
  output logic [11:0]            h_total,
  output logic                   overflow
);

  localparam logic        HS_ACT = 1'(HS_POL);
  localparam logic        VS_ACT = 1'(VS_POL);
  localparam logic [12:0] H_LO   = 13'(H_START);
  localparam logic [12:0] H_HI   = 13'(H_START + H_ACTIVE);
  localparam logic [11:0] V_LO   = 12'(V_START);
  localparam logic [11:0] V_HI   = 12'(V_START + V_ACTIVE);
  localparam logic [11:0] H_SAT  = 12'hFFF;
  localparam logic [10:0] V_SAT  = 11'h7FF;

  typedef enum logic [1:0] {SEEK, RUN, SKIP} state_t;

  logic       r_s1_hs, r_s1_vs, r_s2_hs, r_s2_vs;
  logic [7:0] r_s1_r, r_s1_g, r_s1_b;
  logic [11:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  state_t     r_state;
  logic       r_wr_en;
  logic [15:0] r_wr_data;
  logic       r_frame_start;
  logic [11:0] r_h_total;
  logic       r_overflow;

  logic        w_hs_edge, w_vs_edge;
  logic [11:0] w_h_cur;
  logic [10:0] w_v_cur;
  logic        w_in_win;
  logic [15:0] w_pack;
  state_t      w_state_next;
  logic        w_wr;
  logic        w_ovf_set;

  assign w_hs_edge = r_s1_hs & ~r_s2_hs;
  assign w_vs_edge = r_s1_vs & ~r_s2_vs;

  // Counts that belong to the pixel currently held in stage 1; a line or
  // frame edge restarts the count on the very pixel that carries the edge.
  assign w_h_cur = w_hs_edge ? 12'd0 : r_h_cnt;
  assign w_v_cur = w_vs_edge ? 11'd0 :
                   (w_hs_edge && r_v_cnt != V_SAT) ? r_v_cnt + 11'd1 : r_v_cnt;

  assign w_in_win = ({1'b0, w_h_cur} >= H_LO) && ({1'b0, w_h_cur} < H_HI) &&
                    ({1'b0, w_v_cur} >= V_LO) && ({1'b0, w_v_cur} < V_HI);

  assign w_pack = {r_s1_r[7:3], r_s1_g[7:2], r_s1_b[7:3]};

  // Input pipeline: normalise sync polarity so that 1 means active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_hs <= 1'b0;
      r_s1_vs <= 1'b0;
      r_s2_hs <= 1'b0;
      r_s2_vs <= 1'b0;
      r_s1_r  <= 8'd0;
      r_s1_g  <= 8'd0;
      r_s1_b  <= 8'd0;
    end else begin
      r_s1_hs <= vga_hsync ~^ HS_ACT;
      r_s1_vs <= vga_vsync ~^ VS_ACT;
      r_s2_hs <= r_s1_hs;
      r_s2_vs <= r_s1_vs;
      r_s1_r  <= vga_r;
      r_s1_g  <= vga_g;
      r_s1_b  <= vga_b;
    end
  end

  // Pixel/line counters and line-length measurement; both saturate so an
  // absent sync never wraps back into the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt   <= H_SAT;
      r_v_cnt   <= V_SAT;
      r_h_total <= 12'd0;
    end else begin
      r_h_cnt <= (w_h_cur == H_SAT) ? H_SAT : w_h_cur + 12'd1;
      r_v_cnt <= w_v_cur;
      // r_h_cnt already holds last pixel count + 1 (saturated) here.
      if (w_hs_edge) begin
        r_h_total <= r_h_cnt;
      end
    end
  end

  // Capture FSM next state and write decision.
  always_comb begin
    w_state_next = r_state;
    w_wr         = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_vs_edge) w_state_next = RUN;
      end
      RUN: begin
        if (w_in_win) begin
          if (fifo.fifo_full) begin
            w_ovf_set = 1'b1;
            if (!w_vs_edge) w_state_next = SKIP;
          end else begin
            w_wr = 1'b1;
          end
        end
      end
      SKIP: begin
        if (w_vs_edge) w_state_next = RUN;
      end
      default: w_state_next = SEEK;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= SEEK;
      r_wr_en       <= 1'b0;
      r_wr_data     <= 16'd0;
      r_frame_start <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_wr_en       <= w_wr;
      r_frame_start <= w_vs_edge;
      if (w_wr) r_wr_data <= w_pack;
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  assign fifo.fifo_wr_en   = r_wr_en;
  assign fifo.fifo_wr_data = r_wr_data;
  assign frame_start       = r_frame_start;
  assign h_total           = r_h_total;
  assign overflow          = r_overflow;

endmodule
